// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN pixel front-end.
// Holds the read-controller FSM encoding and the default image geometry.
package cnn_pkg;

  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } rd_state_t;

  // Counter/coordinate width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pixel_skid_buf.sv
// Two-entry skid buffer for 8-bit pixels; head entry is presented directly
// and stays put until popped.
module pixel_skid_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic [1:0] occupancy
);

  logic [7:0] mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] cnt_r;
  logic       do_push_s;
  logic       do_pop_s;

  // Qualify push/pop against current fill level.
  always_comb begin
    do_pop_s  = pop && (cnt_r != 2'd0);
    do_push_s = push && ((cnt_r != 2'd2) || do_pop_s);
  end

  // Storage, pointers and fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= 8'd0;
      mem_r[1] <= 8'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign occupancy = cnt_r;

endmodule

// File: rtl/pixel_rd_ctrl.sv
// Frame read controller: pulls IMG_W*IMG_H pixels from a FIFO into a skid
// buffer and streams them with coordinates. Optional PIXEL_RD_CTRL_STATS_EN adds o_stall_cnt.
module pixel_rd_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  localparam int ROW_W = clog2_min1(IMG_H),
  localparam int COL_W = clog2_min1(IMG_W)
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_fifo_valid,
  input  logic [7:0]       i_fifo_data,
  output logic             o_rd_en,
  input  logic             i_ready,
  output logic [7:0]       o_pixel,
  output logic             o_pixel_valid,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_eof,
  output logic             o_busy,
`ifdef PIXEL_RD_CTRL_STATS_EN
  output logic [15:0]      o_stall_cnt,
`endif
  output logic             o_done
);

  localparam int N_PIX = IMG_W * IMG_H;
  localparam int CNT_W = clog2_min1(N_PIX + 1);
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N_PIX);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_PIX - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  rd_state_t        state_r;
  logic [CNT_W-1:0] issued_r;
  logic [CNT_W-1:0] accepted_r;
  logic             inflight_r;
  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic [7:0]       head_s;
  logic [1:0]       occ_s;
  logic             valid_s;
  logic             xfer_s;
  logic             rd_en_s;

  pixel_skid_buf u_skid (
    .clk       (i_sys_clk),
    .rst_n     (i_rst_n),
    .push      (inflight_r),
    .push_data (i_fifo_data),
    .pop       (xfer_s),
    .head_data (head_s),
    .occupancy (occ_s)
  );

  // Read gating: a slot in the skid must exist for every read still in flight.
  always_comb begin
    valid_s = (occ_s != 2'd0);
    xfer_s  = valid_s && i_ready;
    if ((state_r == STREAM) && i_fifo_valid && (issued_r < N_CNT) &&
        (({1'b0, occ_s} + {2'b00, inflight_r}) < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Frame FSM with issue/accept counters and output coordinates.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      issued_r   <= '0;
      accepted_r <= '0;
      inflight_r <= 1'b0;
      row_r      <= '0;
      col_r      <= '0;
    end else begin
      inflight_r <= rd_en_s;
      if (rd_en_s) begin
        issued_r <= issued_r + CNT_W'(1);
      end
      if (xfer_s) begin
        accepted_r <= accepted_r + CNT_W'(1);
        if (col_r == LAST_COL) begin
          col_r <= '0;
          row_r <= (row_r == LAST_ROW) ? '0 : row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r    <= STREAM;
            issued_r   <= '0;
            accepted_r <= '0;
            row_r      <= '0;
            col_r      <= '0;
          end
        end
        STREAM: begin
          if (rd_en_s && (issued_r == LAST_IDX)) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer_s && (accepted_r == LAST_IDX)) begin
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef PIXEL_RD_CTRL_STATS_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of FIFO-starved streaming cycles, cleared by an accepted start.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == IDLE) && i_start) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == STREAM) && !i_fifo_valid && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_r;
`endif

  assign o_rd_en       = rd_en_s;
  assign o_pixel       = head_s;
  assign o_pixel_valid = valid_s;
  assign o_row         = row_r;
  assign o_col         = col_r;
  assign o_sof         = valid_s && (row_r == '0) && (col_r == '0);
  assign o_eol         = valid_s && (col_r == LAST_COL);
  assign o_eof         = valid_s && (row_r == LAST_ROW) && (col_r == LAST_COL);
  assign o_busy        = (state_r == STREAM) || (state_r == DRAIN);
  assign o_done        = (state_r == DONE);

endmodule

// File: tb/tb_pixel_rd_ctrl.sv
// Randomized self-checking bench for pixel_rd_ctrl (28x28 and 4x2 instances)
// against a frame-level model of the pixel stream.
module tb_pixel_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_b = 1'b0, start_s = 1'b0;
  logic       fifo_valid = 1'b0;
  logic [7:0] fifo_data = 8'd0;
  logic       ready = 1'b0;

  logic       b_rd_en, b_valid, b_sof, b_eol, b_eof, b_busy, b_done;
  logic [7:0] b_pixel;
  logic [4:0] b_row, b_col;
  logic       s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done;
  logic [7:0] s_pixel;
  logic [0:0] s_row;
  logic [1:0] s_col;
`ifdef PIXEL_RD_CTRL_STATS_EN
  logic [15:0] b_stall, s_stall;
`endif

  always #5 clk = ~clk;

  pixel_rd_ctrl dut (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data), .o_rd_en(b_rd_en),
    .i_ready(ready), .o_pixel(b_pixel), .o_pixel_valid(b_valid),
    .o_row(b_row), .o_col(b_col), .o_sof(b_sof), .o_eol(b_eol), .o_eof(b_eof),
    .o_busy(b_busy),
`ifdef PIXEL_RD_CTRL_STATS_EN
    .o_stall_cnt(b_stall),
`endif
    .o_done(b_done)
  );

  pixel_rd_ctrl #(.IMG_W(4), .IMG_H(2)) dut_s (
    .i_sys_clk(clk), .i_rst_n(rst_n), .i_start(start_s),
    .i_fifo_valid(fifo_valid), .i_fifo_data(fifo_data), .o_rd_en(s_rd_en),
    .i_ready(ready), .o_pixel(s_pixel), .o_pixel_valid(s_valid),
    .o_row(s_row), .o_col(s_col), .o_sof(s_sof), .o_eol(s_eol), .o_eof(s_eof),
    .o_busy(s_busy),
`ifdef PIXEL_RD_CTRL_STATS_EN
    .o_stall_cnt(s_stall),
`endif
    .o_done(s_done)
  );

  // Selected-instance view used by the common checker
  logic       sel = 1'b0;
  logic       m_rd_en, m_valid, m_sof, m_eol, m_eof, m_busy, m_done;
  logic [7:0] m_pixel;
  int         m_row, m_col;

  always_comb begin
    m_rd_en = sel ? s_rd_en : b_rd_en;
    m_valid = sel ? s_valid : b_valid;
    m_sof   = sel ? s_sof   : b_sof;
    m_eol   = sel ? s_eol   : b_eol;
    m_eof   = sel ? s_eof   : b_eof;
    m_busy  = sel ? s_busy  : b_busy;
    m_done  = sel ? s_done  : b_done;
    m_pixel = sel ? s_pixel : b_pixel;
    m_row   = sel ? int'(s_row) : int'(b_row);
    m_col   = sel ? int'(s_col) : int'(b_col);
  end

  int checks = 0, failures = 0;
  int W = 28, N = 784;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  int  phase = 0, idx = 0, issued = 0, acc = 0, cyc = 0;
  bit  rd_pend = 1'b0;
  logic [7:0] pend_data = 8'd0;
  bit  prev_stall = 1'b0;
  logic [31:0] prev_vec = '0;
  int  ready_mode = 0;
  bit  hold_low = 1'b0, start_req = 1'b0;
  int  n_xfer, n_sof, n_eol, n_eof, n_done, n_rd, n_rd_hold;
  int  last_pix, last_row, last_col, xfer_cyc, done_cyc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_xfer = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0; n_rd_hold = 0;
  endtask

  task automatic load_frame(input int kind);
    logic [7:0] b;
    q.delete(); exp_q.delete();
    for (int i = 0; i < N; i++) begin
      b = (kind == 0) ? 8'(i % 256) : 8'($urandom);
      q.push_back(b); exp_q.push_back(b);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then check the
  // values the next rising edge will see and advance the frame model.
  task automatic step();
    bit st, xfer;
    logic [31:0] vec;
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0: ready = 1'b1;
      1: ready = (cyc % 3 == 0);
      default: ready = 1'($urandom_range(0, 1));
    endcase
    fifo_valid = (q.size() > 0) && !hold_low;
    fifo_data  = rd_pend ? pend_data : 8'($urandom);
    st = start_req;
    start_b = st && !sel;
    start_s = st && sel;
    start_req = 1'b0;
    #1;
    chk("busy", m_busy, phase == 1);
    chk("done", m_done, phase == 2);
    if (m_done) begin n_done++; done_cyc = cyc; end
    if (m_rd_en) begin
      chk("rd_allowed", fifo_valid && (phase == 1) && (issued < N), 1);
      issued++; n_rd++;
      if (hold_low) n_rd_hold++;
      rd_pend = 1'b1;
      pend_data = (q.size() > 0) ? q.pop_front() : 8'd0;
    end else begin
      rd_pend = 1'b0;
    end
    chk("outstanding_le2", (issued - acc) <= 2, 1);
    vec = {6'd0, m_valid, m_pixel, 8'(m_row), 8'(m_col), m_sof, m_eol, m_eof};
    if (prev_stall) chk("stable_while_stalled", vec, prev_vec);
    xfer = m_valid && ready;
    if (m_valid) begin
      chk("valid_in_frame", phase, 1);
      chk("pix_in_range", idx < N, 1);
      chk("pixel", m_pixel, (idx < exp_q.size()) ? exp_q[idx] : 8'd0);
      chk("row", m_row, idx / W);
      chk("col", m_col, idx % W);
      chk("flags", {m_sof, m_eol, m_eof}, {idx == 0, (idx % W) == W - 1, idx == N - 1});
    end
    if (xfer) begin
      n_xfer++; n_sof += m_sof; n_eol += m_eol; n_eof += m_eof;
      if (idx == N - 1) begin
        last_pix = m_pixel; last_row = m_row; last_col = m_col; xfer_cyc = cyc;
      end
      idx++; acc++;
    end
    prev_stall = m_valid && !ready;
    prev_vec = vec;
    if (phase == 2) phase = 0;
    else if (phase == 0 && st) begin phase = 1; idx = 0; issued = 0; acc = 0; end
    else if (phase == 1 && xfer && idx == N) phase = 2;
  endtask

  task automatic do_reset();
    int rd_before;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_zero",
        {b_rd_en, b_valid, b_sof, b_eol, b_eof, b_busy, b_done, b_pixel, b_row, b_col}, 0);
    phase = 0; idx = 0; issued = 0; acc = 0; rd_pend = 1'b0; prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_held_idle", {b_rd_en, b_busy, b_valid}, 0);
    rst_n = 1'b1;
    rd_before = n_rd;
    repeat (20) step();
    chk("no_rd_after_reset", n_rd - rd_before, 0);
  endtask

  task automatic run_frame(input int hold_at, input int mid_start_at, input int rst_at);
    int hold_cnt;
    bit stall_checked, mid_done, ended;
    hold_cnt = 0; stall_checked = 1'b0; mid_done = 1'b0; ended = 1'b0;
    start_req = 1'b1;
    step();
    for (int k = 0; k < 8000; k++) begin
      hold_low = (hold_at >= 0) && (acc >= hold_at) && (hold_cnt < 50);
      if (hold_low) hold_cnt++;
      if (mid_start_at >= 0 && !mid_done && acc >= mid_start_at) begin
        start_req = 1'b1; mid_done = 1'b1;
      end
      step();
      if (hold_cnt == 50 && !hold_low && !stall_checked) begin
        stall_checked = 1'b1;
        chk("rd_during_underflow", n_rd_hold, 0);
`ifdef PIXEL_RD_CTRL_STATS_EN
        chk("stall_cnt", b_stall, 50);
`endif
      end
      if (rst_at >= 0 && acc >= rst_at) begin
        do_reset(); ended = 1'b1; break;
      end
      if (phase == 0) begin ended = 1'b1; break; end
    end
    if (!ended) chk("frame_timeout", phase, 0);
    hold_low = 1'b0;
  endtask

  initial begin
    n_rd = 0; clear_stats();
    last_pix = -1; last_row = -1; last_col = -1; xfer_cyc = 0; done_cyc = 0;
    #3;
    chk("reset_big", {b_rd_en, b_valid, b_sof, b_eol, b_eof, b_busy, b_done, b_pixel, b_row, b_col}, 0);
    chk("reset_small", {s_rd_en, s_valid, s_sof, s_eol, s_eof, s_busy, s_done, s_pixel, s_row, s_col}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cyclic 0..255 frame, always ready
    load_frame(0); ready_mode = 0;
    run_frame(-1, -1, -1);
    chk("A_transfers", n_xfer, 784);
    chk("A_sof", n_sof, 1);
    chk("A_eol", n_eol, 28);
    chk("A_eof", n_eof, 1);
    chk("A_done", n_done, 1);
    chk("A_last_pix", last_pix, 15);
    chk("A_last_row", last_row, 27);
    chk("A_last_col", last_col, 27);
    chk("A_done_gap", done_cyc - xfer_cyc, 1);

    // Ready one cycle in three, random data
    clear_stats(); load_frame(1); ready_mode = 1;
    run_frame(-1, -1, -1);
    chk("B_transfers", n_xfer, 784);

    // 50-cycle FIFO underflow mid-frame
    clear_stats(); load_frame(0); ready_mode = 0;
    run_frame(200, -1, -1);
    chk("C_transfers", n_xfer, 784);

    // Stray start during streaming, random ready
    clear_stats(); load_frame(1); ready_mode = 2;
    run_frame(-1, 300, -1);
    chk("D_issued", issued, 784);
    chk("D_transfers", n_xfer, 784);

    // Reset after 300 transfers, then a clean frame
    clear_stats(); load_frame(0); ready_mode = 0;
    run_frame(-1, -1, 300);
    clear_stats(); load_frame(0);
    run_frame(-1, -1, -1);
    chk("F_transfers", n_xfer, 784);
    chk("F_done", n_done, 1);

    // 4x2 instance: two back-to-back frames, restart right after done
    sel = 1'b1; W = 4; N = 8; clear_stats(); ready_mode = 2;
    load_frame(1);
    run_frame(-1, -1, -1);
    load_frame(1);
    run_frame(-1, -1, -1);
    chk("S_transfers", n_xfer, 16);
    chk("S_sof", n_sof, 2);
    chk("S_eol", n_eol, 4);
    chk("S_eof", n_eof, 2);
    chk("S_done", n_done, 2);
    chk("S_last_row", last_row, 1);
    chk("S_last_col", last_col, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_rd_ctrl.md
PIXEL_RD_CTRL -- requirements
Module: pixel_rd_ctrl

Interface
REQ-001 The block SHALL take parameter IMG_W, default 28: pixels per row.
REQ-002 The block SHALL take parameter IMG_H, default 28: rows per frame.
REQ-003 The block SHALL have i_sys_clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 The block SHALL have i_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have i_start, input, 1: a one-cycle pulse that begins one frame.
REQ-006 The block SHALL have i_fifo_valid, input, 1: the pixel FIFO is not empty.
REQ-007 The block SHALL have i_fifo_data, input, 8: FIFO read data, valid one cycle after o_rd_en.
REQ-008 The block SHALL have o_rd_en, output, 1: FIFO read strobe.
REQ-009 The block SHALL have i_ready, input, 1: the downstream conv layer accepts a pixel.
REQ-010 The block SHALL have o_pixel, output, 8, and o_pixel_valid, output, 1: the pixel stream.
REQ-011 The block SHALL have o_row and o_col, outputs, $clog2 width: coordinates of o_pixel.
REQ-012 The block SHALL have o_sof, o_eol and o_eof, outputs, 1: start of frame, end of row and end of frame, each qualified by o_pixel_valid.
REQ-013 The block SHALL have o_busy, output, 1: the frame is in progress.
REQ-014 The block SHALL have o_done, output, 1: a one-cycle pulse after the last pixel is accepted.

Function
REQ-015 The FSM SHALL have the states IDLE, STREAM, DRAIN and DONE.
REQ-016 The FSM SHALL move IDLE->STREAM on i_start, STREAM->DRAIN when IMG_W*IMG_H reads have been issued, DRAIN->DONE when the last pixel is accepted (o_pixel_valid && i_ready), and DONE->IDLE unconditionally after one cycle.
REQ-017 i_start outside IDLE SHALL be ignored.
REQ-018 o_rd_en SHALL be asserted only when all of these hold: state is STREAM, i_fifo_valid is high, issued count < IMG_W*IMG_H, and skid occupancy + reads in flight < 2.
REQ-019 Read data SHALL be captured into a 2-entry skid buffer exactly one cycle after o_rd_en; no pixel SHALL be dropped or duplicated.
REQ-020 o_pixel_valid SHALL equal "skid buffer not empty"; a pixel is transferred when o_pixel_valid && i_ready.
REQ-021 o_pixel, o_row, o_col and the flags SHALL stay stable while o_pixel_valid is high and i_ready is low.
REQ-022 o_col SHALL advance on each transfer and wrap IMG_W-1->0; o_row SHALL advance on each wrap.
REQ-023 o_sof SHALL be high only at (0,0), o_eol only at col IMG_W-1, and o_eof only at (IMG_H-1, IMG_W-1).
REQ-024 When i_fifo_valid drops (underflow), reads SHALL pause with no error; the stream resumes when it rises again.
REQ-025 The issued counter and the accepted counter SHALL each be wide enough for IMG_W*IMG_H with no wrap within a frame.
REQ-026 o_busy SHALL be high in STREAM and DRAIN.
REQ-027 o_done SHALL be high only in DONE.
REQ-028 The DONE cycle SHALL allow a new i_start to be accepted on the next cycle, in IDLE.

Reset
REQ-029 On i_rst_n low, immediately and asynchronously, the block SHALL go to IDLE and clear the counters and the skid buffer.
REQ-030 While in reset, o_rd_en, o_pixel_valid, o_sof, o_eol, o_eof, o_busy and o_done SHALL be 0, and o_pixel, o_row and o_col SHALL be 0.
REQ-031 Reset mid-frame SHALL discard in-flight data, and no o_rd_en SHALL occur until the next i_start.

Configuration
REQ-032 With PIXEL_RD_CTRL_STATS_EN defined, the block SHALL add output o_stall_cnt[15:0], counting STREAM cycles with i_fifo_valid low; it clears on i_start, saturates at 16'hFFFF, and resets to 0.
REQ-033 Without PIXEL_RD_CTRL_STATS_EN, the port and the counter SHALL be absent.

Structure
REQ-034 The FSM state enum (rd_state_t) and the default IMG_W/IMG_H constants SHALL live in the shared package cnn_pkg.
REQ-035 The 2-entry skid buffer SHALL be the sub-module pixel_skid_buf (8-bit data plus occupancy output).

Verification
REQ-036 The bench SHALL cover: FIFO pre-filled with 784 bytes 0..255 cyclic, i_ready=1, one i_start -> 784 transfers in order, o_sof on the first, o_eol every 28th, o_eof on the 784th, o_done one cycle after the last.
REQ-037 The bench SHALL cover: i_ready toggling 1-of-3 cycles -> no loss or duplication, outputs stable while stalled, never more than 2 reads outstanding.
REQ-038 The bench SHALL cover: i_fifo_valid low for 50 cycles mid-frame -> o_rd_en low throughout, stream resumes, and o_stall_cnt=50 when STATS_EN is defined.
REQ-039 The bench SHALL cover: i_start pulsed during STREAM -> ignored, with exactly 784 reads issued.
REQ-040 The bench SHALL cover: i_rst_n low after 300 transfers -> all outputs 0 within the same cycle, IDLE, and no o_rd_en until a new i_start.
REQ-041 The bench SHALL cover: i_start on the cycle after o_done with IMG_W=4, IMG_H=2 -> a second frame of 8 pixels with correct coordinates.
